bkm_slot_bus_if: RTL and testbench
==================================

# bkm_slot_bus_if

Parametrised second-generation option-slot bus interface for the BKM monitor card. It oversamples the monitor's slot bus (clk_rw, ax_d, r_wx, data_in_x) in the clk_50mhz_in domain and decodes init, ID and register transactions against a configurable register file. Card-side event causes are queued to the monitor through an interrupt cause FIFO. It sits between the slot connector pins and the card's video-control logic, which consumes the register write strobes.

## Interface
Parameters:
- NUM_REGS, 16, card registers; power of two, 2..128.
- REG_BASE, 8'h20, command byte offset for the register-access function.
- ID_VALUE, 8'h88, byte returned on an ID read.
- IRQ_DEPTH, 8, cause FIFO entries; power of two, 2..16.
- DEFAULT_SLOT, 2, slot number used until the monitor assigns one.

Ports:
- clk_50mhz_in  in  1  system clock.
- reset_x  in  1  asynchronous, active-low reset.
- clk_rw  in  1  monitor bus strobe; sampled, never used as a clock.
- ax_d  in  1  0 = address/command byte, 1 = data byte.
- r_wx  in  1  1 = monitor reads, 0 = monitor writes.
- slot_x_int_x  in  1  active-low slot select for init transactions.
- data_in_x  in  8  inverted bus data; internal value is ~data_in_x.
- data_out  out  8  byte driven to the bus.
- data_oe_x  out  1  active-low bus drive enable.
- int_x  out  1  active-low interrupt request.
- int_oe_x  out  1  active-low interrupt pin enable.
- slot_no  out  4  assigned slot number.
- reg_wr_stb  out  1  one-cycle pulse on a register write.
- reg_addr  out  log2(NUM_REGS)  register index of the current or last access.
- reg_wdata  out  8  write data, valid with reg_wr_stb.
- reg_rdata  in  8*NUM_REGS  flattened read-back values, register i in bits [8i+7:8i].
- evt_valid  in  1  push request for a cause code.
- evt_code  in  8  cause code; 8'hFF is reserved and must not be pushed.
- evt_ready  out  1  FIFO can accept a cause code.

## Operation
- Sampling: 2-flop synchroniser on every bus input. A bus cycle is a rising edge of the synchronised clk_rw. All inputs are taken from the same synchronised sample.
- Command byte: ax_d=0 at a bus cycle. Byte 8'hFF always returns the FSM to IDLE and releases data_oe_x.
- States: IDLE, INIT_IDX, INIT_DATA, REG_IDX, REG_DATA, ID, WAIT_FF.
- IDLE transitions:
  - 8'h10 with slot_x_int_x=0 and r_wx=0 → INIT_IDX.
  - {slot_no,4'h0} → ID.
  - {slot_no,4'h0}+REG_BASE[3:0]+1 → REG_IDX.
  - Any other byte → WAIT_FF.
- INIT_IDX: latch index byte → INIT_DATA.
- INIT_DATA: behaviour depends on the latched index, then → WAIT_FF.
  - 0x03 write: slot_no <= data[3:0]. Only 2..4 are accepted; other values are ignored.
  - 0x41 read: returns the FIFO head, or 8'hFF when empty.
  - 0x41 write: any value pops the head.
  - Other indices: reads return 8'hFF, writes are ignored.
- REG_IDX: latch the low bits into reg_addr → REG_DATA.
- REG_DATA, then → WAIT_FF:
  - Read: data_out <= reg_rdata[reg_addr].
  - Write: reg_wdata <= data and pulse reg_wr_stb.
  - Index ≥ NUM_REGS: reads return 8'hFF, writes produce no strobe.
- ID: data_out <= ID_VALUE → WAIT_FF.
- WAIT_FF: hold until the 8'hFF command byte.
- Drive: data_oe_x = 0 only when the FSM is in a read data phase, the synchronised r_wx=1, ax_d=1 and reset_x=1.
- Interrupt: int_x = 0 and int_oe_x = 0 while the FIFO is non-empty.

## Timing
- Reset values:
  - data_out = 8'hFF; data_oe_x = 1; int_x = 1; int_oe_x = 1.
  - slot_no = DEFAULT_SLOT; reg_wr_stb = 0; reg_addr = 0; reg_wdata = 0.
  - FIFO empty; evt_ready = 1; FSM in IDLE.
- Latency: the decision is taken 3 clk_50mhz_in cycles after the clk_rw pin rises (2 synchroniser cycles plus 1 edge-detect cycle). data_out and data_oe_x are registered, valid by cycle 4. reg_wr_stb asserts on cycle 4.
- Bus timing: minimum clk_rw high or low time is 3 clk cycles. Shorter pulses may be missed.
- FIFO push: occurs on a cycle with evt_valid & evt_ready. evt_ready = !full.
- FIFO pop: occurs in the cycle that decodes a 0x41 write.
- Simultaneous push and pop:
  - When full: both occur and the occupancy is unchanged.
  - When empty: the push is taken and the pop is ignored.
- Reset mid-transaction: the FSM is forced to IDLE, the FIFO is flushed and the bus is released immediately (asynchronously).

## Configuration
- BKM_IRQ_FIFO_EN defined: full IRQ_DEPTH-entry cause FIFO as described above.
- Not defined: single cause register with last-write-wins behaviour.
  - evt_ready is tied to 1.
  - A push overwrites any pending cause.
  - A 0x41 write clears it.

## Test plan
- Reset then an ID transaction (cmd 8'h20, then data read): data_out = 8'h88 with data_oe_x = 0 during the read phase; the 8'hFF command releases the bus.
- Init write index 0x03, data 0x03: slot_no = 3. A following cmd 8'h20 goes to WAIT_FF; cmd 8'h30 returns ID_VALUE.
- Register write: cmd 8'h21, index 0x05, data 0x5A with r_wx=0 → single reg_wr_stb pulse, reg_addr = 5, reg_wdata = 8'h5A. Index 0x1F with NUM_REGS=16: a read returns 8'hFF and a write produces no strobe.
- Push causes 0xFB then 0xEF: int_x = 0. Init read 0x41 returns 0xFB. Write 0x41 pops, and the next read returns 0xEF. A second pop gives int_x = 1 and a read of 0xFF.
- FIFO boundary (BKM_IRQ_FIFO_EN): push 8 codes → evt_ready = 0. Push and pop in the same cycle → occupancy stays 8 and the head advances.
- Assert reset_x in the REG_DATA read phase: data_oe_x = 1 immediately, FSM in IDLE, FIFO empty.

Source files
------------

// File: rtl/bkm_slot_bus_if_if.sv
// Slot-connector bus between the BKM monitor and the option card.
// The monitor side drives the strobe, command/data and select lines; the card returns data and interrupt.
interface bkm_slot_bus_if_if;
    logic       clk_rw;
    logic       ax_d;
    logic       r_wx;
    logic       slot_x_int_x;
    logic [7:0] data_in_x;
    logic [7:0] data_out;
    logic       data_oe_x;
    logic       int_x;
    logic       int_oe_x;

    modport master (
        output clk_rw, ax_d, r_wx, slot_x_int_x, data_in_x,
        input  data_out, data_oe_x, int_x, int_oe_x
    );

    modport slave (
        input  clk_rw, ax_d, r_wx, slot_x_int_x, data_in_x,
        output data_out, data_oe_x, int_x, int_oe_x
    );
endinterface

// File: rtl/bkm_slot_bus_if.sv
// BKM option-slot bus decoder: init/ID/register transactions plus interrupt cause queue (BKM_IRQ_FIFO_EN selects full FIFO).
// Latency: decode 3 clk_50mhz_in cycles after clk_rw rises; data_out/data_oe_x/reg_wr_stb registered on that edge.
// Backpressure: evt_ready = !full (FIFO) or constant 1 (single last-write-wins cause register); the bus side has none.
module bkm_slot_bus_if #(
    parameter int         NUM_REGS     = 16,
    parameter logic [7:0] REG_BASE     = 8'h20,
    parameter logic [7:0] ID_VALUE     = 8'h88,
    parameter int         IRQ_DEPTH    = 8,
    parameter int         DEFAULT_SLOT = 2
) (
    input  logic                        clk_50mhz_in,
    input  logic                        reset_x,
    bkm_slot_bus_if_if.slave            bus,
    output logic [3:0]                  slot_no,
    output logic                        reg_wr_stb,
    output logic [$clog2(NUM_REGS)-1:0] reg_addr,
    output logic [7:0]                  reg_wdata,
    input  logic [8*NUM_REGS-1:0]       reg_rdata,
    input  logic                        evt_valid,
    input  logic [7:0]                  evt_code,
    output logic                        evt_ready
);
    localparam int         AW         = $clog2(NUM_REGS);
    localparam logic [8:0] NUM_REGS_B = 9'(NUM_REGS);

    if (NUM_REGS < 2 || NUM_REGS > 128 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
        $error("NUM_REGS must be a power of two in 2..128");
    end
    if (IRQ_DEPTH < 2 || IRQ_DEPTH > 16 || (IRQ_DEPTH & (IRQ_DEPTH - 1)) != 0) begin : g_bad_irq_depth
        $error("IRQ_DEPTH must be a power of two in 2..16");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_INIT_IDX, S_INIT_DATA, S_REG_IDX, S_REG_DATA, S_ID, S_WAIT_FF
    } state_t;

    // Strobe synchroniser resets high so an idle-high or idle-low strobe never fakes a rising edge.
    logic [1:0] clk_rw_q, ax_d_q, r_wx_q, sel_q;
    logic [7:0] din_q1, din_q2;
    logic       clk_rw_d;

    always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
        if (!reset_x) begin
            clk_rw_q <= 2'b11;
            ax_d_q   <= 2'b00;
            r_wx_q   <= 2'b00;
            sel_q    <= 2'b11;
            din_q1   <= 8'hFF;
            din_q2   <= 8'hFF;
            clk_rw_d <= 1'b1;
        end else begin
            clk_rw_q <= {clk_rw_q[0], bus.clk_rw};
            ax_d_q   <= {ax_d_q[0], bus.ax_d};
            r_wx_q   <= {r_wx_q[0], bus.r_wx};
            sel_q    <= {sel_q[0], bus.slot_x_int_x};
            din_q1   <= bus.data_in_x;
            din_q2   <= din_q1;
            clk_rw_d <= clk_rw_q[1];
        end
    end

    logic       bus_cyc, ax_s, rw_s, sel_s;
    logic [7:0] bus_byte;
    assign bus_cyc  = clk_rw_q[1] & ~clk_rw_d;
    assign ax_s     = ax_d_q[1];
    assign rw_s     = r_wx_q[1];
    assign sel_s    = sel_q[1];
    assign bus_byte = ~din_q2;

    state_t     state;
    logic [7:0] init_idx;
    logic       reg_oor, rd_hold;
    logic [7:0] data_out_q;
    logic       data_oe_q;
    logic       pop, not_empty;
    logic [7:0] head;

    assign pop = bus_cyc & ax_s & ~rw_s & (state == S_INIT_DATA) & (init_idx == 8'h41);

`ifdef BKM_IRQ_FIFO_EN
    localparam int            PW       = $clog2(IRQ_DEPTH);
    localparam logic [PW:0]   FULL_CNT = IRQ_DEPTH[PW:0];

    logic [7:0]    fifo_mem [IRQ_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   fifo_cnt;
    logic          full, do_push, do_pop;

    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign full      = (fifo_cnt == FULL_CNT);
    assign not_empty = (fifo_cnt != '0);
    assign do_pop    = pop & not_empty;
    assign do_push   = evt_valid & (~full | do_pop);
    assign evt_ready = ~full;
    assign head      = fifo_mem[rd_ptr];

    always_ff @(posedge clk_50mhz_in) begin
        if (do_push) fifo_mem[wr_ptr] <= evt_code;
    end

    always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
        if (!reset_x) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
`else
    logic [7:0] cause;
    logic       cause_vld;

    assign not_empty = cause_vld;
    assign evt_ready = 1'b1;
    assign head      = cause;

    always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
        if (!reset_x) begin
            cause     <= 8'h00;
            cause_vld <= 1'b0;
        end else if (evt_valid) begin
            cause     <= evt_code;
            cause_vld <= 1'b1;
        end else if (pop) begin
            cause_vld <= 1'b0;
        end
    end
`endif

    logic [7:0] rd_val;
    logic       data_state, drive_state;
    logic [7:0] id_cmd, reg_cmd;

    assign data_state  = (state == S_ID) || (state == S_INIT_DATA) || (state == S_REG_DATA);
    assign drive_state = data_state || ((state == S_WAIT_FF) && rd_hold);
    assign id_cmd      = {slot_no, 4'h0};
    assign reg_cmd     = {slot_no, 4'h0} + {4'h0, REG_BASE[3:0]} + 8'd1;

    always_comb begin
        rd_val = 8'hFF;
        case (state)
            S_ID:        rd_val = ID_VALUE;
            S_INIT_DATA: if (init_idx == 8'h41 && not_empty) rd_val = head;
            S_REG_DATA:  if (!reg_oor) rd_val = reg_rdata[{reg_addr, 3'b000} +: 8];
            default:     rd_val = 8'hFF;
        endcase
    end

    // data_out tracks the read value throughout the data phase so it is stable before the monitor samples it.
    always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
        if (!reset_x) begin
            state      <= S_IDLE;
            init_idx   <= 8'h00;
            reg_oor    <= 1'b0;
            rd_hold    <= 1'b0;
            data_out_q <= 8'hFF;
            data_oe_q  <= 1'b1;
            slot_no    <= 4'(DEFAULT_SLOT);
            reg_wr_stb <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= 8'h00;
        end else begin
            reg_wr_stb <= 1'b0;
            data_oe_q  <= ~(drive_state & rw_s & ax_s);
            if (data_state) data_out_q <= rd_val;
            if (bus_cyc) begin
                if (!ax_s && bus_byte == 8'hFF) begin
                    state      <= S_IDLE;
                    rd_hold    <= 1'b0;
                    data_out_q <= 8'hFF;
                    data_oe_q  <= 1'b1;
                end else begin
                    case (state)
                        S_IDLE: if (!ax_s) begin
                            if (bus_byte == 8'h10 && !sel_s && !rw_s) state <= S_INIT_IDX;
                            else if (bus_byte == id_cmd)              state <= S_ID;
                            else if (bus_byte == reg_cmd)             state <= S_REG_IDX;
                            else                                      state <= S_WAIT_FF;
                        end
                        S_INIT_IDX: if (ax_s) begin
                            init_idx <= bus_byte;
                            state    <= S_INIT_DATA;
                        end
                        S_INIT_DATA: if (ax_s) begin
                            if (!rw_s && init_idx == 8'h03 && bus_byte[3:0] >= 4'd2 && bus_byte[3:0] <= 4'd4)
                                slot_no <= bus_byte[3:0];
                            rd_hold <= rw_s;
                            state   <= S_WAIT_FF;
                        end
                        S_REG_IDX: if (ax_s) begin
                            reg_addr <= bus_byte[AW-1:0];
                            reg_oor  <= ({1'b0, bus_byte} >= NUM_REGS_B);
                            state    <= S_REG_DATA;
                        end
                        S_REG_DATA: if (ax_s) begin
                            if (!rw_s && !reg_oor) begin
                                reg_wdata  <= bus_byte;
                                reg_wr_stb <= 1'b1;
                            end
                            rd_hold <= rw_s;
                            state   <= S_WAIT_FF;
                        end
                        S_ID: if (ax_s) begin
                            rd_hold <= rw_s;
                            state   <= S_WAIT_FF;
                        end
                        default: state <= state;
                    endcase
                end
            end
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.data_oe_x = data_oe_q;
    assign bus.int_x     = ~not_empty;
    assign bus.int_oe_x  = ~not_empty;

endmodule

// File: tb/tb_bkm_slot_bus_if.sv
// Randomised bench for bkm_slot_bus_if: bus transactions driven at pin level, checked against a queue/array model.
module tb_bkm_slot_bus_if;
    localparam logic [7:0] REG_BASE = 8'h20;
`ifdef BKM_IRQ_FIFO_EN
    localparam int QDEPTH = 8;
`else
    localparam int QDEPTH = 1;
`endif

    logic clk_50mhz_in = 1'b0;
    logic reset_x      = 1'b0;
    always #10 clk_50mhz_in = ~clk_50mhz_in;

    bkm_slot_bus_if_if bus();
    logic [3:0]   slot_no;
    logic         reg_wr_stb;
    logic [3:0]   reg_addr;
    logic [7:0]   reg_wdata;
    logic [127:0] reg_rdata;
    logic         evt_valid = 1'b0;
    logic [7:0]   evt_code  = 8'h00;
    logic         evt_ready;

    bkm_slot_bus_if #(.NUM_REGS(16), .REG_BASE(REG_BASE), .ID_VALUE(8'h88), .IRQ_DEPTH(8), .DEFAULT_SLOT(2)) dut (
        .clk_50mhz_in(clk_50mhz_in), .reset_x(reset_x), .bus(bus),
        .slot_no(slot_no), .reg_wr_stb(reg_wr_stb), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rmodel [16];
    logic [7:0] q[$];
    logic [3:0] exp_slot = 4'd2;
    int         stb_cnt = 0;
    logic [3:0] stb_addr;
    logic [7:0] stb_data;

    always @(negedge clk_50mhz_in) begin
        if (reg_wr_stb === 1'b1) begin
            stb_cnt  = stb_cnt + 1;
            stb_addr = reg_addr;
            stb_data = reg_wdata;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [7:0] reg_cmd();
        return {exp_slot, 4'h0} + (REG_BASE & 8'h0F) + 8'h01;
    endfunction

    function automatic logic [7:0] model_head();
        return (q.size() > 0) ? q[0] : 8'hFF;
    endfunction

    function automatic void model_push(input logic [7:0] c);
        if (QDEPTH == 1) begin
            q.delete();
            q.push_back(c);
        end else if (q.size() < QDEPTH) begin
            q.push_back(c);
        end
    endfunction

    function automatic logic model_ready();
        return (QDEPTH == 1) ? 1'b1 : (q.size() < QDEPTH);
    endfunction

    // One bus cycle: setup, strobe high, sample outputs late in the high phase, strobe low.
    task automatic bus_cyc(input logic ax, input logic rw, input logic [7:0] b, input logic sel,
                           output logic [7:0] dout, output logic oe);
        bus.ax_d = ax; bus.r_wx = rw; bus.data_in_x = ~b; bus.slot_x_int_x = sel;
        repeat (4) @(posedge clk_50mhz_in);
        bus.clk_rw = 1'b1;
        repeat (5) @(posedge clk_50mhz_in);
        #1;
        dout = bus.data_out;
        oe   = bus.data_oe_x;
        bus.clk_rw = 1'b0;
        repeat (4) @(posedge clk_50mhz_in);
    endtask

    task automatic cmd(input logic [7:0] b);
        logic [7:0] d; logic o;
        bus_cyc(1'b0, 1'b0, b, 1'b1, d, o);
    endtask

    task automatic wr(input logic [7:0] b);
        logic [7:0] d; logic o;
        bus_cyc(1'b1, 1'b0, b, 1'b1, d, o);
    endtask

    task automatic rd(output logic [7:0] d, output logic o);
        bus_cyc(1'b1, 1'b1, 8'hFF, 1'b1, d, o);
    endtask

    task automatic init_cmd();
        logic [7:0] d; logic o;
        bus_cyc(1'b0, 1'b0, 8'h10, 1'b0, d, o);
    endtask

    task automatic irq_read(output logic [7:0] v);
        logic o;
        init_cmd(); wr(8'h41); rd(v, o); cmd(8'hFF);
    endtask

    task automatic irq_pop();
        init_cmd(); wr(8'h41); wr(8'($urandom)); cmd(8'hFF);
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic push_evt(input logic [7:0] c);
        @(negedge clk_50mhz_in);
        evt_valid = 1'b1; evt_code = c;
        @(negedge clk_50mhz_in);
        evt_valid = 1'b0;
        model_push(c);
    endtask

    task automatic test_reset();
        bus.clk_rw = 1'b0; bus.ax_d = 1'b0; bus.r_wx = 1'b0; bus.slot_x_int_x = 1'b1; bus.data_in_x = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            rmodel[i] = 8'($urandom);
            reg_rdata[i*8 +: 8] = rmodel[i];
        end
        repeat (3) @(posedge clk_50mhz_in);
        @(negedge clk_50mhz_in) reset_x = 1'b1;
        repeat (2) @(negedge clk_50mhz_in);
        checks++; if (bus.data_out !== 8'hFF) begin errors++; $display("FAIL reset_data_out got %h exp ff", bus.data_out); end
        checks++; if (bus.data_oe_x !== 1'b1) begin errors++; $display("FAIL reset_oe got %b exp 1", bus.data_oe_x); end
        checks++; if ({bus.int_x, bus.int_oe_x} !== 2'b11) begin errors++; $display("FAIL reset_int got %b exp 11", {bus.int_x, bus.int_oe_x}); end
        checks++; if (slot_no !== 4'd2) begin errors++; $display("FAIL reset_slot got %0d exp 2", slot_no); end
        checks++; if ({reg_wr_stb, reg_addr, reg_wdata} !== 13'h0) begin errors++; $display("FAIL reset_reg got %h exp 0", {reg_wr_stb, reg_addr, reg_wdata}); end
        checks++; if (evt_ready !== 1'b1) begin errors++; $display("FAIL reset_evt_ready got %b exp 1", evt_ready); end
    endtask

    task automatic test_id();
        logic [7:0] d; logic o;
        cmd({exp_slot, 4'h0}); rd(d, o);
        checks++; if (d !== 8'h88) begin errors++; $display("FAIL id_data got %h exp 88", d); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL id_oe got %b exp 0", o); end
        cmd(8'hFF);
        checks++; if (bus.data_oe_x !== 1'b1) begin errors++; $display("FAIL id_release got %b exp 1", bus.data_oe_x); end
    endtask

    task automatic test_slot();
        logic [7:0] d; logic o;
        init_cmd(); wr(8'h03); wr(8'h03); cmd(8'hFF);
        exp_slot = 4'd3;
        checks++; if (slot_no !== exp_slot) begin errors++; $display("FAIL slot_set got %0d exp %0d", slot_no, exp_slot); end
        init_cmd(); wr(8'h03); wr(8'h07); cmd(8'hFF);
        checks++; if (slot_no !== exp_slot) begin errors++; $display("FAIL slot_reject got %0d exp %0d", slot_no, exp_slot); end
        cmd(8'h20); rd(d, o);
        checks++; if (o !== 1'b1) begin errors++; $display("FAIL old_slot_wait got oe %b exp 1", o); end
        cmd(8'hFF);
        cmd(8'h30); rd(d, o);
        checks++; if (d !== 8'h88 || o !== 1'b0) begin errors++; $display("FAIL new_slot_id got %h/%b exp 88/0", d, o); end
        cmd(8'hFF);
    endtask

    task automatic reg_access(input logic [7:0] idx, input logic [7:0] val, input logic is_rd);
        logic [7:0] d; logic o; int s0;
        s0 = stb_cnt;
        cmd(reg_cmd()); wr(idx);
        if (is_rd) begin
            rd(d, o);
            checks++; if (d !== ((idx < 16) ? rmodel[idx[3:0]] : 8'hFF) || o !== 1'b0) begin
                errors++; $display("FAIL reg_read idx %h got %h/%b exp %h/0", idx, d, o, (idx < 16) ? rmodel[idx[3:0]] : 8'hFF);
            end
        end else begin
            wr(val);
            checks++; if (stb_cnt - s0 !== ((idx < 16) ? 1 : 0)) begin
                errors++; $display("FAIL reg_strobes idx %h got %0d exp %0d", idx, stb_cnt - s0, (idx < 16) ? 1 : 0);
            end
            if (idx < 16) begin
                checks++; if (stb_addr !== idx[3:0] || stb_data !== val) begin
                    errors++; $display("FAIL reg_write got %h/%h exp %h/%h", stb_addr, stb_data, idx[3:0], val);
                end
            end
        end
        checks++; if (reg_addr !== idx[3:0]) begin errors++; $display("FAIL reg_addr got %h exp %h", reg_addr, idx[3:0]); end
        cmd(8'hFF);
    endtask

    task automatic test_registers();
        reg_access(8'h05, 8'h5A, 1'b0);
        reg_access(8'h1F, 8'h00, 1'b1);
        reg_access(8'h1F, 8'h33, 1'b0);
        for (int i = 0; i < 12; i++)
            reg_access(8'($urandom_range(0, 31)), 8'($urandom), 1'($urandom));
    endtask

    task automatic test_irq_basic();
        logic [7:0] v;
        push_evt(8'hFB); push_evt(8'hEF);
        checks++; if ({bus.int_x, bus.int_oe_x} !== 2'b00) begin errors++; $display("FAIL irq_pending got %b exp 00", {bus.int_x, bus.int_oe_x}); end
        for (int i = 0; i < 2; i++) begin
            irq_read(v);
            checks++; if (v !== model_head()) begin errors++; $display("FAIL irq_head%0d got %h exp %h", i, v, model_head()); end
            irq_pop();
        end
        irq_read(v);
        checks++; if (v !== 8'hFF || bus.int_x !== 1'b1) begin errors++; $display("FAIL irq_empty got %h/%b exp ff/1", v, bus.int_x); end
    endtask

    task automatic test_irq_random();
        logic [7:0] v;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 2))
                0: if (model_ready()) push_evt(8'($urandom_range(0, 254)));
                1: irq_pop();
                default: begin
                    irq_read(v);
                    checks++; if (v !== model_head()) begin errors++; $display("FAIL irq_rand_head got %h exp %h", v, model_head()); end
                end
            endcase
            checks++; if (bus.int_x !== (q.size() == 0) || evt_ready !== model_ready()) begin
                errors++; $display("FAIL irq_rand_flags got %b/%b exp %b/%b", bus.int_x, evt_ready, q.size() == 0, model_ready());
            end
        end
    endtask

`ifdef BKM_IRQ_FIFO_EN
    task automatic test_fifo_full();
        logic [7:0] v;
        while (q.size() > 0) irq_pop();
        for (int i = 1; i <= 8; i++) push_evt(8'(i));
        checks++; if (evt_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready got %b exp 0", evt_ready); end
        init_cmd(); wr(8'h41);
        evt_code = 8'h99; evt_valid = 1'b1;
        wr(8'h00);
        evt_valid = 1'b0;
        cmd(8'hFF);
        void'(q.pop_front()); q.push_back(8'h99);
        checks++; if (evt_ready !== 1'b0) begin errors++; $display("FAIL fifo_pushpop_ready got %b exp 0", evt_ready); end
        for (int i = 0; i < 8; i++) begin
            irq_read(v);
            checks++; if (v !== model_head()) begin errors++; $display("FAIL fifo_drain%0d got %h exp %h", i, v, model_head()); end
            irq_pop();
        end
        checks++; if (bus.int_x !== 1'b1) begin errors++; $display("FAIL fifo_drained_int got %b exp 1", bus.int_x); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [7:0] d; logic o;
        push_evt(8'h5C);
        cmd(reg_cmd()); wr(8'h02);
        bus.ax_d = 1'b1; bus.r_wx = 1'b1; bus.data_in_x = 8'hFF;
        repeat (4) @(posedge clk_50mhz_in);
        #1;
        checks++; if (bus.data_oe_x !== 1'b0 || bus.data_out !== rmodel[2]) begin
            errors++; $display("FAIL mid_drive got %h/%b exp %h/0", bus.data_out, bus.data_oe_x, rmodel[2]);
        end
        @(negedge clk_50mhz_in);
        #2 reset_x = 1'b0;
        #1;
        checks++; if (bus.data_oe_x !== 1'b1 || bus.int_x !== 1'b1 || evt_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset got oe %b int %b rdy %b exp 1 1 1", bus.data_oe_x, bus.int_x, evt_ready);
        end
        q.delete(); exp_slot = 4'd2;
        bus.ax_d = 1'b0; bus.r_wx = 1'b0;
        @(negedge clk_50mhz_in) reset_x = 1'b1;
        repeat (2) @(posedge clk_50mhz_in);
        cmd(8'h20); rd(d, o);
        checks++; if (d !== 8'h88 || o !== 1'b0) begin errors++; $display("FAIL after_reset_id got %h/%b exp 88/0", d, o); end
        cmd(8'hFF);
    endtask

    initial begin
        test_reset();
        test_id();
        test_slot();
        test_registers();
        test_irq_basic();
        test_irq_random();
`ifdef BKM_IRQ_FIFO_EN
        test_fifo_full();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
